lz_sweep_gen: RTL and testbench
===============================

LZ_SWEEP_GEN -- requirements
Module: lz_sweep_gen

Interface
REQ-001 The block SHALL have parameter: LFSR_SEED, default 31'h0000_0001, initial 31-bit LFSR state; a value of 0 SHALL be replaced by 1.
REQ-002 The block SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: start  in  1  request one generation run; sampled only in IDLE.
REQ-005 The block SHALL have port: mode  in  1  0 = sweep (33 beats), 1 = single beat; sampled with start.
REQ-006 The block SHALL have port: lz_req  in  6  leading-zero count for single mode; values >32 saturate to 32.
REQ-007 The block SHALL have port: vec  out  32  generated vector for the counting block under test.
REQ-008 The block SHALL have port: lz_exp  out  6  expected leading-zero count of vec.
REQ-009 The block SHALL have port: out_valid  out  1  vec/lz_exp valid.
REQ-010 The block SHALL have port: out_ready  in  1  consumer accepts beat.
REQ-011 The block SHALL have port: busy  out  1  high in any state except IDLE.
REQ-012 The block SHALL have port: done  out  1  one-cycle pulse after the final beat of a run transfers.

Function
REQ-013 The FSM SHALL have states IDLE, EMIT and DONE: IDLE->EMIT on start; EMIT->DONE on last-beat transfer; DONE->IDLE unconditionally after one cycle.
REQ-014 On start acceptance at edge N, the block SHALL latch base = {1'b1, lfsr} and the LFSR SHALL advance once; out_valid SHALL be high from cycle N+1.
REQ-015 Each beat SHALL present vec = base >> k and lz_exp = k, so k=32 gives vec=0 and lz_exp=32.
REQ-016 In sweep mode, k SHALL run 0,1,...,32, advancing by 1 per transfer, for exactly 33 beats.
REQ-017 In single mode, k SHALL equal saturated lz_req for exactly 1 beat.
REQ-018 A transfer SHALL occur on a rising edge with out_valid && out_ready; vec and lz_exp SHALL be held stable while out_valid && !out_ready.
REQ-019 Back-to-back transfers SHALL be supported (one beat per cycle with out_ready held high); out_valid SHALL stay high between beats of a run.
REQ-020 out_valid SHALL fall in the cycle after the last transfer; done SHALL be high in that cycle (DONE state).
REQ-021 start asserted while busy SHALL be ignored; start asserted in DONE SHALL be ignored.
REQ-022 The LFSR SHALL be a 31-bit Fibonacci LFSR with polynomial x^31+x^28+1, shifting left, with new bit0 = bit30 ^ bit27, advancing only on start acceptance.

Reset
REQ-023 While rst is high: state=IDLE, k=0, base=0, lfsr=LFSR_SEED (or 1 if 0), vec=0, lz_exp=0, out_valid=0, busy=0, done=0.
REQ-024 rst asserted mid-run SHALL abort the run immediately with no done pulse; the next run SHALL restart from the seed.

Configuration
REQ-025 With LZ_GEN_CHECK_EN defined, the block SHALL add ports lz_obs (in, 6), err_cnt (out, 8) and err (out, 1).
REQ-026 With LZ_GEN_CHECK_EN defined, on each transfer where lz_obs != lz_exp, err_cnt SHALL increment, saturating at 255, and err SHALL set sticky; both SHALL clear on rst only.
REQ-027 With LZ_GEN_CHECK_EN undefined, these ports and their logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-028 The bench SHALL cover: LFSR_SEED=1, mode=0, start pulse, out_ready=1 -> beats 32'h8000_0001/0, 32'h4000_0000/1, 32'h2000_0000/2 ... 32'h0000_0001/31, 32'h0000_0000/32; 33 beats; done one cycle after the last beat.
REQ-029 The bench SHALL cover: mode=1, lz_req=45, first run after reset -> single beat vec=0, lz_exp=32, then done.
REQ-030 The bench SHALL cover: sweep with out_ready low for 5 cycles at beat k=3 -> vec=32'h1000_0000 and lz_exp=3 held constant, no beat lost, still 33 beats.
REQ-031 The bench SHALL cover: start pulsed at beat 10 of a sweep -> ignored; total 33 beats, single done.
REQ-032 The bench SHALL cover: rst asserted at beat 20 -> outputs 0 asynchronously, no done; a new sweep restarts at 32'h8000_0001.
REQ-033 The bench SHALL cover (with LZ_GEN_CHECK_EN): lz_obs forced to 0 during a full sweep -> err=1, err_cnt=32.

Source files
------------

// File: rtl/lz_sweep_gen.sv
// Leading-zero test vector generator: emits base>>k with expected count k, sweep (k=0..32) or single beat.
// Optional self-check of an observed count against lz_exp is enabled with `define LZ_GEN_CHECK_EN.
module lz_sweep_gen #(
   parameter logic [30:0] LFSR_SEED = 31'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mode,
   input  logic [5:0]  lz_req,
   output logic [31:0] vec,
   output logic [5:0]  lz_exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
`ifdef LZ_GEN_CHECK_EN
   ,
   input  logic [5:0]  lz_obs,
   output logic [7:0]  err_cnt,
   output logic        err
`endif
);

   localparam logic [30:0] SEED_EFF = (LFSR_SEED == 31'd0) ? 31'd1 : LFSR_SEED;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_k;
   logic [31:0] r_base;
   logic [30:0] r_lfsr;
   logic        r_single;

   logic        w_accept;
   logic        w_xfer;
   logic        w_last;
   logic [5:0]  w_req_sat;

   assign w_req_sat = (lz_req > 6'd32) ? 6'd32 : lz_req;
   assign w_last    = r_single || (r_k == 6'd32);

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_xfer    = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_EMIT;
            end
         end
         S_EMIT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            w_xfer    = out_ready;
            if (out_ready && w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The base keeps a forced MSB so k=0 always has zero leading zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k      <= 6'd0;
         r_base   <= 32'd0;
         r_lfsr   <= SEED_EFF;
         r_single <= 1'b0;
      end else if (w_accept) begin
         r_base   <= {1'b1, r_lfsr};
         r_lfsr   <= {r_lfsr[29:0], r_lfsr[30] ^ r_lfsr[27]};
         r_single <= mode;
         r_k      <= mode ? w_req_sat : 6'd0;
      end else if (w_xfer && !w_last) begin
         r_k <= r_k + 6'd1;
      end
   end

   assign vec    = r_base >> r_k;
   assign lz_exp = r_k;

`ifdef LZ_GEN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
         err     <= 1'b0;
      end else if (w_xfer && (lz_obs != r_k)) begin
         err <= 1'b1;
         if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lz_sweep_gen.sv
// Randomised scoreboard bench for lz_sweep_gen: expected beats queued at start acceptance, monitor compares.
module tb_lz_sweep_gen;

   localparam logic [30:0] SEED = 31'h0000_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [5:0]  lz_req = 6'd0;
   logic [31:0] vec;
   logic [5:0]  lz_exp;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        done;
`ifdef LZ_GEN_CHECK_EN
   logic [5:0]  lz_obs;
   logic [7:0]  err_cnt;
   logic        err;
   bit          obs_zero = 1'b0;
   int          exp_err_cnt = 0;
   assign lz_obs = obs_zero ? 6'd0 : lz_exp;
`endif

   lz_sweep_gen #(.LFSR_SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .lz_req(lz_req),
      .vec(vec), .lz_exp(lz_exp), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
`ifdef LZ_GEN_CHECK_EN
      , .lz_obs(lz_obs), .err_cnt(err_cnt), .err(err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] vec;
      logic [5:0]  k;
      bit          last;
   } beat_t;

   beat_t       q[$];
   logic [30:0] m_lfsr = SEED;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          exp_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one run is the list of shifts k applied to {1, lfsr}; lfsr steps once per run.
   task automatic push_run(input bit m, input logic [5:0] req);
      logic [31:0] base;
      int          ks;
      base   = {1'b1, m_lfsr};
      m_lfsr = {m_lfsr[29:0], m_lfsr[30] ^ m_lfsr[27]};
      if (m) begin
         ks = (req > 32) ? 32 : int'(req);
         q.push_back('{vec: base >> ks, k: 6'(ks), last: 1'b1});
      end else begin
         for (int k = 0; k <= 32; k++)
            q.push_back('{vec: base >> k, k: 6'(k), last: (k == 32)});
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (exp_done) begin
            check("done_pulse", {31'd0, done}, 32'd1);
            check("valid_fall", {31'd0, out_valid}, 32'd0);
            exp_done = 1'b0;
         end else if (done) begin
            check("spurious_done", {31'd0, done}, 32'd0);
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_beat", {31'd0, out_valid}, 32'd0);
            end else begin
               check("vec", vec, q[0].vec);
               check("lz_exp", {26'd0, lz_exp}, {26'd0, q[0].k});
               if (out_ready) begin
`ifdef LZ_GEN_CHECK_EN
                  if (obs_zero && q[0].k != 6'd0 && exp_err_cnt < 255) exp_err_cnt++;
`endif
                  if (q[0].last) exp_done = 1'b1;
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_vec", vec, 32'd0);
      check("rst_lz_exp", {26'd0, lz_exp}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
`ifdef LZ_GEN_CHECK_EN
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      exp_err_cnt = 0;
`endif
      q.delete();
      exp_done = 1'b0;
      m_lfsr   = SEED;
      start    = 1'b0;
      out_ready = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   // stall_k/start_k/rst_k < 0 disable that disturbance; first_vec != 0 adds a literal check of beat 0.
   task automatic run_case(input bit m, input logic [5:0] req, input int stall_k, input int start_k,
                           input int rst_k, input bit rnd, input logic [31:0] first_vec);
      int  stall_left;
      bit  stalled;
      bit  poked;
      bit  finished;
      check("idle_before_start", {31'd0, busy}, 32'd0);
      mode   = m;
      lz_req = req;
      start  = 1'b1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      push_run(m, req);
      step();
      start  = 1'b0;
      lz_req = 6'($urandom);
      mode   = 1'($urandom);
      check("valid_after_start", {31'd0, out_valid}, 32'd1);
      if (first_vec != 32'd0) check("first_vec", vec, first_vec);
      stall_left = 0; stalled = 0; poked = 0; finished = 0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         if (done) begin
            finished = 1;
         end else if (rst_k >= 0 && out_valid && int'(lz_exp) == rst_k) begin
            do_reset();
            return;
         end else begin
            start = 1'b0;
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else if (!stalled && out_valid && int'(lz_exp) == stall_k) begin
               out_ready = 1'b0;
               stall_left = 4;
               stalled = 1;
            end else begin
               out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (!poked && out_valid && int'(lz_exp) == start_k) begin
               start = 1'b1;
               poked = 1;
            end
            step();
         end
      end
      if (!finished) check("run_timeout", 32'd0, 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_in_done_ignored", {31'd0, busy}, 32'd0);
      check("queue_drained", q.size(), 32'd0);
   endtask

   initial begin
      #2;
      check("rst_vec", vec, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      step();
      rst = 1'b0;
      step();
      run_case(1'b1, 6'd45, -1, -1, -1, 1'b0, 32'd0);
      do_reset();
      run_case(1'b0, 6'd0, -1, -1, -1, 1'b0, 32'h8000_0001);
      run_case(1'b0, 6'd0, 3, -1, -1, 1'b0, 32'd0);
      run_case(1'b0, 6'd0, -1, 10, -1, 1'b0, 32'd0);
      run_case(1'b0, 6'd0, -1, -1, 20, 1'b0, 32'd0);
      run_case(1'b0, 6'd0, -1, -1, -1, 1'b0, 32'h8000_0001);
      run_case(1'b1, 6'd0, -1, -1, -1, 1'b0, 32'd0);
      run_case(1'b1, 6'd31, -1, -1, -1, 1'b1, 32'd0);
      run_case(1'b1, 6'd32, -1, -1, -1, 1'b1, 32'd0);
      run_case(1'b1, 6'd33, -1, -1, -1, 1'b1, 32'd0);
      run_case(1'b1, 6'd63, -1, -1, -1, 1'b1, 32'd0);
      for (int i = 0; i < 12; i++) begin
         bit          rm;
         logic [5:0]  rq;
         rm = 1'($urandom);
         rq = 6'($urandom);
         run_case(rm, rq, int'($urandom_range(0, 40)) - 4, -1, -1, 1'b1, 32'd0);
      end
`ifdef LZ_GEN_CHECK_EN
      do_reset();
      obs_zero = 1'b1;
      run_case(1'b0, 6'd0, -1, -1, -1, 1'b1, 32'd0);
      obs_zero = 1'b0;
      check("err_sticky", {31'd0, err}, 32'd1);
      check("err_cnt", {24'd0, err_cnt}, 32'(exp_err_cnt));
      check("err_cnt_sweep", {24'd0, err_cnt}, 32'd32);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
